// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register"
// marker and the pipeline-control state encoding. The pipeline registers use
// the same constants.
package y86_pkg;

    // Instruction codes that the control logic cares about
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Architectural status codes
    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    // Register id meaning "no destination / no source"
    localparam logic [3:0] RNONE = 4'hF;

    // Run/drain/halt control states; the encoding is visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Purely combinational hazard terms for the five-stage pipeline:
// load/use data hazard, return in flight, and mispredicted conditional jump.
module hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       e_Cnd,
    output logic       load_use,
    output logic       ret_in,
    output logic       mispred
);

    logic e_is_load;

    // Evaluate hazard conditions from the current pipeline-register contents
    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on
        // every path; a missing assignment would infer a latch.
        e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);
        load_use  = e_is_load && (E_dstM != RNONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_in    = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        mispred   = (E_icode == IJXX) && !e_Cnd;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage Y86-64 core: per-register stall/bubble
// decisions, a run/drain/halt state machine that freezes the pipeline once an
// exception reaches write-back, and saturating cycle/retire counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [3:0]       proc_stat,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    logic load_use;
    logic ret_in;
    logic mispred;
    logic m_exc;
    logic w_exc;
    logic active;

    ctrl_state_e      state_q,      state_d;
    logic [3:0]       proc_stat_q,  proc_stat_d;
    logic [CNT_W-1:0] cycle_cnt_q,  cycle_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    hazard_detect u_hazard_detect (
        .D_icode  (D_icode),
        .E_icode  (E_icode),
        .M_icode  (M_icode),
        .E_dstM   (E_dstM),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .e_Cnd    (e_Cnd),
        .load_use (load_use),
        .ret_in   (ret_in),
        .mispred  (mispred)
    );

    assign m_exc  = (m_stat != SAOK);
    assign w_exc  = (W_stat != SAOK);
    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Next control state; the exception status is captured on entry to HALTED
    always_comb begin
        state_d     = state_q;
        proc_stat_d = proc_stat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_exc) begin
                    state_d     = ST_HALTED;
                    proc_stat_d = W_stat;
                end else if (m_exc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Older instructions keep flowing to W; no way back to RUN
                if (w_exc) begin
                    state_d     = ST_HALTED;
                    proc_stat_d = W_stat;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Saturating performance counters, live only while the pipeline moves
    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (active && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        // Bubbles carry NOP and the faulting instruction carries a non-AOK stat
        if (active && !w_exc && (W_icode != INOP) && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    // State, status and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            proc_stat_q  <= SAOK;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs regardless of statement order.
            state_q      <= state_d;
            proc_stat_q  <= proc_stat_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Stall/bubble gating: hazard-driven while active, fully frozen otherwise
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        if (active) begin
            F_stall  = load_use | ret_in;
            D_stall  = load_use;
            // A load/use stall holds D, so the return bubble must wait
            D_bubble = mispred | (ret_in & ~load_use);
            E_bubble = mispred | load_use;
            M_bubble = m_exc | w_exc;
            W_stall  = w_exc;
        end
    end

    assign state      = state_q;
    assign proc_stat  = proc_stat_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int TB_CNT_W = 6;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                go;
    logic [3:0]          D_icode, E_icode, M_icode, W_icode;
    logic [3:0]          E_dstM, d_srcA, d_srcB;
    logic                e_Cnd;
    logic [3:0]          m_stat, W_stat;
    logic                F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [3:0]          proc_stat;
    logic [1:0]          state;
    logic [TB_CNT_W-1:0] cycle_cnt, retire_cnt;
    logic [5:0]          outs;

    int err_cnt = 0;
    int chk_cnt = 0;

    pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .D_icode    (D_icode),
        .E_icode    (E_icode),
        .M_icode    (M_icode),
        .W_icode    (W_icode),
        .E_dstM     (E_dstM),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .e_Cnd      (e_Cnd),
        .m_stat     (m_stat),
        .W_stat     (W_stat),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .E_bubble   (E_bubble),
        .M_bubble   (M_bubble),
        .W_stall    (W_stall),
        .proc_stat  (proc_stat),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Packed view of the control outputs: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    assign outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet pipeline: NOPs everywhere except an ordinary retiring op in W
    task automatic neutral_inputs();
        go      = 1'b0;
        D_icode = 4'h1;
        E_icode = 4'h1;
        M_icode = 4'h1;
        W_icode = 4'h6;
        E_dstM  = 4'hF;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        e_Cnd   = 1'b1;
        m_stat  = 4'h1;
        W_stat  = 4'h1;
    endtask

    task automatic pulse_reset();
        tick();
        neutral_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset();
        neutral_inputs();
        rst = 1'b1;
        #3;
        chk_cnt++;
        if (state !== 2'd0 || proc_stat !== 4'h1) begin
            err_cnt++;
            $display("FAIL reset_state: state=%0d proc_stat=%0d, expected 0/1", state, proc_stat);
        end
        chk_cnt++;
        if (cycle_cnt !== '0 || retire_cnt !== '0) begin
            err_cnt++;
            $display("FAIL reset_counters: cycle=%0d retire=%0d, expected 0/0", cycle_cnt, retire_cnt);
        end
        chk_cnt++;
        if (outs !== 6'b110001) begin
            err_cnt++;
            $display("FAIL reset_frozen: outs=%b expected 110001", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (state !== 2'd0 || cycle_cnt !== '0) begin
            err_cnt++;
            $display("FAIL idle_wait: state=%0d cycle=%0d, expected 0/0", state, cycle_cnt);
        end
    endtask

    task automatic test_run_count();
        start_run();
        @(negedge clk);
        chk_cnt++;
        if (state !== 2'd1 || cycle_cnt !== '0) begin
            err_cnt++;
            $display("FAIL go_to_run: state=%0d cycle=%0d, expected 1/0", state, cycle_cnt);
        end
        repeat (5) tick();
        @(negedge clk);
        chk_cnt++;
        if (state !== 2'd1 || cycle_cnt !== 6'd5 || retire_cnt !== 6'd5) begin
            err_cnt++;
            $display("FAIL run_5: state=%0d cycle=%0d retire=%0d, expected 1/5/5",
                     state, cycle_cnt, retire_cnt);
        end
        chk_cnt++;
        if (outs !== 6'b000000) begin
            err_cnt++;
            $display("FAIL run_quiet: outs=%b expected 000000", outs);
        end
    endtask

    task automatic test_load_use();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        @(negedge clk);
        chk_cnt++;
        if (outs !== 6'b110100) begin
            err_cnt++;
            $display("FAIL load_use_srcA: outs=%b expected 110100", outs);
        end
        d_srcA = 4'h4; d_srcB = 4'h4;
        #1;
        chk_cnt++;
        if (outs !== 6'b000000) begin
            err_cnt++;
            $display("FAIL load_use_nomatch: outs=%b expected 000000", outs);
        end
        E_icode = 4'hB; E_dstM = 4'h4;
        #1;
        chk_cnt++;
        if (outs !== 6'b110100) begin
            err_cnt++;
            $display("FAIL load_use_popq_srcB: outs=%b expected 110100", outs);
        end
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        #1;
        chk_cnt++;
        if (outs !== 6'b000000) begin
            err_cnt++;
            $display("FAIL load_use_rnone: outs=%b expected 000000", outs);
        end
        neutral_inputs();
        tick();
    endtask

    task automatic test_ret();
        for (int i = 0; i < 5; i++) begin
            D_icode = (i < 3)  ? 4'h9 : 4'h1;
            E_icode = (i == 3) ? 4'h9 : 4'h1;
            M_icode = (i == 4) ? 4'h9 : 4'h1;
            @(negedge clk);
            chk_cnt++;
            if (outs !== 6'b101000) begin
                err_cnt++;
                $display("FAIL ret_step%0d: outs=%b expected 101000", i, outs);
            end
            tick();
        end
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; M_icode = 4'h1;
        @(negedge clk);
        chk_cnt++;
        if (outs !== 6'b110100) begin
            err_cnt++;
            $display("FAIL ret_with_load_use: outs=%b expected 110100", outs);
        end
        neutral_inputs();
        tick();
    endtask

    task automatic test_mispred();
        E_icode = 4'h7; e_Cnd = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (outs !== 6'b001100) begin
            err_cnt++;
            $display("FAIL mispred_taken_wrong: outs=%b expected 001100", outs);
        end
        e_Cnd = 1'b1;
        #1;
        chk_cnt++;
        if (outs !== 6'b000000) begin
            err_cnt++;
            $display("FAIL mispred_correct: outs=%b expected 000000", outs);
        end
        neutral_inputs();
        tick();
    endtask

    task automatic test_exception();
        pulse_reset();
        start_run();
        m_stat = 4'h3;
        @(negedge clk);
        chk_cnt++;
        if (outs !== 6'b000010 || state !== 2'd1) begin
            err_cnt++;
            $display("FAIL exc_m_stage: outs=%b state=%0d, expected 000010/1", outs, state);
        end
        tick();
        m_stat = 4'h1; W_stat = 4'h3;
        @(negedge clk);
        chk_cnt++;
        if (state !== 2'd2 || proc_stat !== 4'h1 || outs !== 6'b000011) begin
            err_cnt++;
            $display("FAIL exc_drain: state=%0d proc=%0d outs=%b, expected 2/1/000011",
                     state, proc_stat, outs);
        end
        tick();
        W_stat = 4'h1; go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (state !== 2'd3 || proc_stat !== 4'h3 || outs !== 6'b110001 ||
                cycle_cnt !== 6'd2 || retire_cnt !== 6'd1) begin
                err_cnt++;
                $display("FAIL exc_halted%0d: state=%0d proc=%0d outs=%b cyc=%0d ret=%0d, expected 3/3/110001/2/1",
                         i, state, proc_stat, outs, cycle_cnt, retire_cnt);
            end
            tick();
        end
        go = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        start_run();
        m_stat = 4'h2;
        tick();
        m_stat = 4'h1;
        @(negedge clk);
        chk_cnt++;
        if (state !== 2'd2) begin
            err_cnt++;
            $display("FAIL mid_reset_setup: state=%0d expected 2", state);
        end
        #1;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (state !== 2'd0 || proc_stat !== 4'h1 || cycle_cnt !== '0 || retire_cnt !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset_async: state=%0d proc=%0d cyc=%0d ret=%0d, expected 0/1/0/0",
                     state, proc_stat, cycle_cnt, retire_cnt);
        end
        rst = 1'b0;
        tick();
        start_run();
        @(negedge clk);
        chk_cnt++;
        if (state !== 2'd1 || outs !== 6'b000000) begin
            err_cnt++;
            $display("FAIL restart_run: state=%0d outs=%b, expected 1/000000", state, outs);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        start_run();
        repeat (CNT_MAX + 8) tick();
        @(negedge clk);
        chk_cnt++;
        if (cycle_cnt !== 6'h3F || retire_cnt !== 6'h3F) begin
            err_cnt++;
            $display("FAIL saturate: cyc=%0d ret=%0d, expected %0d/%0d",
                     cycle_cnt, retire_cnt, CNT_MAX, CNT_MAX);
        end
    endtask

    task automatic test_random();
        logic [3:0] icodes [8] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
        int  ms, mproc, mcyc, mret;
        bit  lu, rt, mp, mx, wx;
        logic [5:0] exp_outs;

        pulse_reset();
        ms = 0; mproc = 1; mcyc = 0; mret = 0;
        for (int n = 0; n < 600; n++) begin
            if (ms == 3 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                ms = 0; mproc = 1; mcyc = 0; mret = 0;
            end
            go      = ($urandom_range(0, 3) == 0);
            D_icode = icodes[$urandom_range(0, 7)];
            E_icode = icodes[$urandom_range(0, 7)];
            M_icode = icodes[$urandom_range(0, 7)];
            W_icode = icodes[$urandom_range(0, 7)];
            E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            d_srcA  = ($urandom_range(0, 1) == 0) ? E_dstM : 4'($urandom_range(0, 15));
            d_srcB  = ($urandom_range(0, 2) == 0) ? E_dstM : 4'($urandom_range(0, 15));
            e_Cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            W_stat  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
            @(negedge clk);

            if (ms == 0 || ms == 3) begin
                exp_outs = 6'b110001;
            end else begin
                lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                     (E_dstM == d_srcA || E_dstM == d_srcB);
                rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
                mp = (E_icode == 4'h7) && !e_Cnd;
                mx = (m_stat != 4'h1);
                wx = (W_stat != 4'h1);
                exp_outs = {lu | rt, lu, mp | (rt & !lu), mp | lu, mx | wx, wx};
            end
            chk_cnt++;
            if (outs !== exp_outs) begin
                err_cnt++;
                $display("FAIL rnd_outs@%0d: outs=%b expected %b", n, outs, exp_outs);
            end
            chk_cnt++;
            if (state !== 2'(ms) || proc_stat !== 4'(mproc)) begin
                err_cnt++;
                $display("FAIL rnd_state@%0d: state=%0d proc=%0d expected %0d/%0d",
                         n, state, proc_stat, ms, mproc);
            end
            chk_cnt++;
            if (cycle_cnt !== TB_CNT_W'(mcyc) || retire_cnt !== TB_CNT_W'(mret)) begin
                err_cnt++;
                $display("FAIL rnd_counters@%0d: cyc=%0d ret=%0d expected %0d/%0d",
                         n, cycle_cnt, retire_cnt, mcyc, mret);
            end
            chk_cnt++;
            if (D_stall && D_bubble) begin
                err_cnt++;
                $display("FAIL rnd_d_stall_and_bubble@%0d: both asserted", n);
            end

            // Model the coming edge from the stat and state rules
            if (ms == 1 || ms == 2) begin
                mcyc = (mcyc < CNT_MAX) ? mcyc + 1 : CNT_MAX;
                if (W_stat == 4'h1 && W_icode != 4'h1)
                    mret = (mret < CNT_MAX) ? mret + 1 : CNT_MAX;
            end
            if (ms == 0) begin
                if (go) ms = 1;
            end else if (ms == 1 || ms == 2) begin
                if (W_stat != 4'h1) begin
                    ms = 3;
                    mproc = int'(W_stat);
                end else if (ms == 1 && m_stat != 4'h1) begin
                    ms = 2;
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        neutral_inputs();
        #2;
        test_reset();
        test_run_count();
        test_load_use();
        test_ret();
        test_mispred();
        test_exception();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
